dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_4000, meaning the byte address that maps to word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 4096, meaning the number of 32-bit words (power of two, 16..65536).
REQ-003 SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, width 1: synchronous, active-low reset.
REQ-005 SHALL have ports req_valid (input, 1), req_ready (output, 1), req_we (input, 1), req_addr (input, 32), req_size (input, 2: 0 byte, 1 half, 2 word, 3 reserved), req_unsigned (input, 1), req_wdata (input, 32, right-justified).
REQ-006 SHALL have ports resp_valid (output, 1), resp_ready (input, 1), resp_rdata (output, 32, extended load data, 0 for stores), resp_err (output, 1).

Function
REQ-007 SHALL accept a request on a rising edge where req_valid && req_ready.
REQ-008 SHALL compute offset = req_addr - BASE_ADDR modulo 2^32, word index = offset[31:2], lane = offset[1:0].
REQ-009 SHALL flag range error when offset >= 4*DEPTH_WORDS, and size error when req_size==3.
REQ-010 SHALL, for an accepted error-free store, write only the addressed byte lanes in the accept cycle: byte = 1 lane, half = 2 lanes, word = 4 lanes, with data replicated into the lanes.
REQ-011 SHALL, for an accepted error-free load, read the word synchronously in the accept cycle, then select the byte/half by lane and sign-extend it, or zero-extend when req_unsigned=1.
REQ-012 SHALL suppress the write of any errored request, return resp_rdata=0, and set resp_err=1.
REQ-013 SHALL implement an FSM with states IDLE and RESP: IDLE->RESP on accept; RESP->IDLE on resp_ready without a new accept; RESP->RESP on resp_ready with a new accept.
REQ-014 SHALL drive req_ready = (state==IDLE) || resp_ready, giving one-cycle latency and full back-to-back throughput.
REQ-015 SHALL assert resp_valid exactly in RESP, and SHALL hold resp_rdata and resp_err stable while resp_valid && !resp_ready.
REQ-016 SHALL, on a store followed immediately by a load to the same word, return the post-store data, because the write precedes the read in the array.
REQ-017 SHALL NOT read or write the array in any cycle without an accept.

Reset
REQ-018 SHALL, while rst_n=0 at a clock edge, enter IDLE with resp_valid=0, resp_err=0, resp_rdata=0, and req_ready=1 after reset release.
REQ-019 SHALL, on reset mid-response, drop the pending response, and SHALL leave the array contents undefined (not cleared).

Configuration
REQ-020 SHALL honour macro DMEM_MISALIGN_TRAP_EN: when defined, a half access with lane[0]=1 or a word access with lane!=0 is a misalign error handled per REQ-012.
REQ-021 SHALL, without DMEM_MISALIGN_TRAP_EN, force misaligned addresses down to natural alignment (clear low bits) and complete without error.

Structure
REQ-022 SHALL place the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum in shared package dmem_pkg.
REQ-023 SHALL use one sub-module, dmem_bank: a DEPTH_WORDS x 32 array with a 4-bit byte write-enable and a registered read port.
REQ-024 SHALL derive the index width as $clog2(DEPTH_WORDS), with no hard-coded 14-bit slice.

Verification
REQ-025 SHALL cover: word store 0xDEADBEEF @0x4000, then load word @0x4000 -> resp_rdata=0xDEADBEEF, err=0, resp_valid one cycle after each accept.
REQ-026 SHALL cover: byte store 0x80 @0x4003, then signed byte load -> 0xFFFFFF80, unsigned -> 0x00000080, word load -> 0x80ADBEEF.
REQ-027 SHALL cover: load @0x3FFC and @BASE+4*DEPTH_WORDS -> err=1, rdata=0; a store there leaves word 0 and the last word unchanged.
REQ-028 SHALL cover: half load @0x4001 -> err=1 with DMEM_MISALIGN_TRAP_EN, else data of half @0x4000 with err=0.
REQ-029 SHALL cover: resp_ready held 0 for 3 cycles -> resp_rdata stable, req_ready=0, no array access; back-to-back store/load same word -> new data.
REQ-030 SHALL cover: rst_n=0 while in RESP -> next cycle resp_valid=0, req_ready=1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: access sizes, FSM states, lane helpers.
// Latency: n/a (package of constants and pure functions).
// Backpressure: n/a.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    // Byte-lane write enables for an access of the given size starting at an aligned lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << lane;
            SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Pick the byte/half out of a read word and sign- or zero-extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised single-port RAM with per-byte write enables and a registered read port.
// Latency: read data valid the cycle after en; writes land on the same edge.
// Backpressure: none; the array is only touched when en is high.
module dmem_bank #(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // Read data only moves on an enabled access so it stays stable while a response stalls.
    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            rdata_d = mem_q[idx];
        end
    end

    // Byte-masked write and read-data capture; the array is deliberately never reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: decodes byte/half/word loads and stores onto a dmem_bank, flags range/size errors.
// Latency: one cycle from accept to resp_valid; back-to-back accepts when resp_ready is high.
// Backpressure: req_ready drops while a response is held; DMEM_MISALIGN_TRAP_EN turns misalignment into an error.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_4000,
    parameter int          DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);

    state_e state_q, state_d;

    logic             load_q, load_d;
    logic             err_q, err_d;
    logic [1:0]       lane_q, lane_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;

    logic             accept;
    logic [31:0]      offset;
    logic [1:0]       lane_raw;
    logic [1:0]       lane_eff;
    logic [IDX_W-1:0] idx;
    logic             req_err;
    logic [3:0]       be;
    logic [31:0]      wdata_rep;
    logic             bank_en;
    logic [31:0]      bank_rdata;

    assign req_ready = (state_q == ST_IDLE) || resp_ready;
    assign accept    = rst_n && req_valid && req_ready;

    // Address decode, error classification, lane alignment and store lane/data formatting.
    always_comb begin
        offset   = req_addr - BASE_ADDR;
        lane_raw = offset[1:0];
        idx      = offset[IDX_W+1:2];
`ifdef DMEM_MISALIGN_TRAP_EN
        req_err  = (offset >= LIMIT) || (req_size == SZ_RSVD) ||
                   ((req_size == SZ_HALF) && lane_raw[0]) ||
                   ((req_size == SZ_WORD) && (lane_raw != 2'b00));
        lane_eff = lane_raw;
`else
        req_err  = (offset >= LIMIT) || (req_size == SZ_RSVD);
        case (req_size)
            SZ_HALF: lane_eff = {lane_raw[1], 1'b0};
            SZ_WORD: lane_eff = 2'b00;
            default: lane_eff = lane_raw;
        endcase
`endif
        be = 4'b0000;
        if (req_we && !req_err) begin
            be = lane_mask(req_size, lane_eff);
        end
        case (req_size)
            SZ_BYTE: wdata_rep = {4{req_wdata[7:0]}};
            SZ_HALF: wdata_rep = {2{req_wdata[15:0]}};
            default: wdata_rep = req_wdata;
        endcase
        bank_en = accept && !req_err;
    end

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk   (clk),
        .en    (bank_en),
        .be    (be),
        .idx   (idx),
        .wdata (wdata_rep),
        .rdata (bank_rdata)
    );

    // Next state and response attributes captured on accept.
    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        err_d   = err_q;
        lane_d  = lane_q;
        size_d  = size_q;
        uns_d   = uns_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) state_d = accept ? ST_RESP : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            load_d = !req_we;
            err_d  = req_err;
            lane_d = lane_eff;
            size_d = req_size;
            uns_d  = req_unsigned;
        end
    end

    // State and response-attribute registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            lane_q  <= 2'b00;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            err_q   <= err_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
        end
    end

    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && load_q && !err_q) ?
                        load_extend(bank_rdata, lane_q, size_q, uns_q) : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a byte-addressed reference model and a per-cycle compare.
// Latency: model predicts a response one cycle after each accept.
// Backpressure: stimulus exercises resp_ready stalls and back-to-back accepts.
module tb_dmem_ctrl;

    localparam logic [31:0] BASE  = 32'h0000_4000;
    localparam int          DEPTH = 4096;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    bit chk_en   = 1'b0;

    bit [7:0]  mb [4*DEPTH];
    bit        m_valid = 1'b0;
    bit [31:0] m_rdata = 32'h0;
    bit        m_err   = 1'b0;

    dmem_ctrl #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Byte-addressed memory model: computes the response of one accepted request.
    task automatic model_access(input bit we, input bit [31:0] addr, input bit [1:0] sz,
                                input bit uns, input bit [31:0] wd);
        bit [31:0] off, a, w;
        bit        e;
        int        nb;
        off = addr - BASE;
        e   = (off >= 32'(4*DEPTH)) || (sz == 2'd3);
        if (TRAP && (((sz == 2'd1) && off[0]) || ((sz == 2'd2) && (off[1:0] != 2'b00)))) e = 1'b1;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        a   = off & ~32'(nb - 1);
        m_err   = e;
        m_rdata = 32'h0;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < nb; i++) mb[a + i] = wd[8*i +: 8];
            end else begin
                w = 32'h0;
                for (int i = 0; i < nb; i++) w[8*i +: 8] = mb[a + i];
                if (!uns && nb < 4 && w[8*nb-1]) w = w | ~((32'h1 << (8*nb)) - 32'h1);
                m_rdata = w;
            end
        end
    endtask

    // Protocol-level model update at each rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b0;
        end else if (req_valid && (!m_valid || resp_ready)) begin
            model_access(req_we, req_addr, req_size, req_unsigned, req_wdata);
            m_valid = 1'b1;
        end else if (resp_ready) begin
            m_valid = 1'b0;
        end
    end

    // Per-cycle compare of DUT outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("resp_valid", {31'h0, resp_valid}, {31'h0, m_valid});
            chk("req_ready", {31'h0, req_ready}, {31'h0, (!m_valid || resp_ready)});
            if (m_valid) begin
                chk("resp_rdata", resp_rdata, m_rdata);
                chk("resp_err", {31'h0, resp_err}, {31'h0, m_err});
            end
        end
    end

    task automatic do_req(input bit we, input bit [31:0] addr, input bit [1:0] sz, input bit uns,
                          input bit [31:0] wd, output logic [31:0] rd, output logic er);
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = sz;
        req_unsigned = uns; req_wdata = wd; resp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 20) chk("accept_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("resp_latency", {31'h0, resp_valid}, 32'h1);
        rd = resp_rdata;
        er = resp_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
        req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'h0; resp_ready = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Word store / load.
        do_req(1, 32'h4000, 2'd2, 0, 32'hDEADBEEF, rd, er);
        chk("st_word_rdata", rd, 32'h0);
        chk("st_word_err", {31'h0, er}, 32'h0);
        do_req(0, 32'h4000, 2'd2, 0, 32'h0, rd, er);
        chk("ld_word", rd, 32'hDEADBEEF);
        chk("ld_word_err", {31'h0, er}, 32'h0);

        // Byte store, signed/unsigned/word loads.
        do_req(1, 32'h4003, 2'd0, 0, 32'h0000_0080, rd, er);
        do_req(0, 32'h4003, 2'd0, 0, 32'h0, rd, er);
        chk("ld_byte_s", rd, 32'hFFFFFF80);
        do_req(0, 32'h4003, 2'd0, 1, 32'h0, rd, er);
        chk("ld_byte_u", rd, 32'h00000080);
        do_req(0, 32'h4000, 2'd2, 0, 32'h0, rd, er);
        chk("ld_word_after_byte", rd, 32'h80ADBEEF);

        // Range errors at both edges of the window.
        do_req(1, 32'h7FFC, 2'd2, 0, 32'h11223344, rd, er);
        do_req(0, 32'h3FFC, 2'd2, 0, 32'h0, rd, er);
        chk("ld_below_err", {31'h0, er}, 32'h1);
        chk("ld_below_rdata", rd, 32'h0);
        do_req(0, 32'h8000, 2'd2, 0, 32'h0, rd, er);
        chk("ld_above_err", {31'h0, er}, 32'h1);
        chk("ld_above_rdata", rd, 32'h0);
        do_req(1, 32'h8000, 2'd2, 0, 32'hFFFFFFFF, rd, er);
        chk("st_above_err", {31'h0, er}, 32'h1);
        do_req(1, 32'h3FFC, 2'd2, 0, 32'hFFFFFFFF, rd, er);
        chk("st_below_err", {31'h0, er}, 32'h1);
        do_req(0, 32'h4000, 2'd2, 0, 32'h0, rd, er);
        chk("word0_intact", rd, 32'h80ADBEEF);
        do_req(0, 32'h7FFC, 2'd2, 0, 32'h0, rd, er);
        chk("last_word_intact", rd, 32'h11223344);

        // Halves, misalignment, reserved size.
        do_req(0, 32'h4001, 2'd1, 0, 32'h0, rd, er);
        chk("ld_half_mis_err", {31'h0, er}, TRAP ? 32'h1 : 32'h0);
        chk("ld_half_mis_rdata", rd, TRAP ? 32'h0 : 32'hFFFFBEEF);
        do_req(0, 32'h4002, 2'd1, 0, 32'h0, rd, er);
        chk("ld_half_hi_s", rd, 32'hFFFF80AD);
        do_req(0, 32'h4000, 2'd3, 0, 32'h0, rd, er);
        chk("ld_rsvd_err", {31'h0, er}, 32'h1);
        chk("ld_rsvd_rdata", rd, 32'h0);
        do_req(1, 32'h4010, 2'd2, 0, 32'h0, rd, er);
        do_req(1, 32'h4012, 2'd1, 0, 32'h0000ABCD, rd, er);
        do_req(0, 32'h4010, 2'd2, 0, 32'h0, rd, er);
        chk("st_half_word", rd, 32'hABCD0000);
        do_req(0, 32'h4012, 2'd1, 1, 32'h0, rd, er);
        chk("ld_half_u", rd, 32'h0000ABCD);

        // Stalled response: data held, req_ready low, pending store not taken.
        do_req(1, 32'h4008, 2'd2, 0, 32'h55667788, rd, er);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4008; req_size = 2'd2; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_we = 1'b1; req_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_rdata", resp_rdata, 32'h55667788);
            chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        do_req(0, 32'h4008, 2'd2, 0, 32'h0, rd, er);
        chk("stall_no_write", rd, 32'h55667788);

        // Back-to-back store then load of the same word.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h400C; req_size = 2'd2; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_we = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_load", resp_rdata, 32'hCAFEF00D);

        // Reset while a response is pending.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4000; req_size = 2'd2; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", {31'h0, resp_valid}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_valid", {31'h0, resp_valid}, 32'h0);
        chk("mid_rst_ready", {31'h0, req_ready}, 32'h1);
        chk("mid_rst_rdata", resp_rdata, 32'h0);
        chk("mid_rst_err", {31'h0, resp_err}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
